// File: rtl/flag_synchronizer.sv
// Multi-flop synchronizer for one asynchronous flag into the fast_clk domain.
// Define SYNC_PULSE_EN for one-cycle pulse per rising edge; otherwise level output.
module flag_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic fast_clk,
  input  logic rst,
  input  logic flag,
  output logic flag_out
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 8) begin : g_bad_stages
    $error("flag_synchronizer: SYNC_STAGES must be in 2..8");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_flag_out;
  logic                   w_sync_last;

  assign w_sync_last = r_sync[SYNC_STAGES-1];
  assign flag_out    = r_flag_out;

  // flag enters only at r_sync[0]; nothing downstream sees it combinationally
  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], flag};
  end

`ifdef SYNC_PULSE_EN
  logic r_hist;

  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      r_hist     <= 1'b0;
      r_flag_out <= 1'b0;
    end else begin
      r_hist     <= w_sync_last;
      r_flag_out <= w_sync_last & ~r_hist;
    end
  end
`else
  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) r_flag_out <= 1'b0;
    else     r_flag_out <= w_sync_last;
  end
`endif

endmodule

// File: tb/tb_flag_synchronizer.sv
// Randomized scoreboard bench for flag_synchronizer; model works on per-edge flag samples.
module tb_flag_synchronizer;
`ifdef SYNC_PULSE_EN
  localparam int N = 2;
`else
  localparam int N = 3;
`endif

  logic fast_clk = 1'b0;
  logic rst;
  logic flag;
  logic flag_out;

  int   vectors     = 0;
  int   miscompares = 0;
  logic exp_q[$];
  logic hist[$];

  flag_synchronizer #(.SYNC_STAGES(N)) dut (
    .fast_clk (fast_clk),
    .rst      (rst),
    .flag     (flag),
    .flag_out (flag_out)
  );

  always #5 fast_clk = ~fast_clk;

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // hist[0] is the flag sampled at the latest edge; output lags the sample by N edges
  function automatic logic ref_out();
`ifdef SYNC_PULSE_EN
    return hist[N] & ~hist[N+1];
`else
    return hist[N];
`endif
  endfunction

  always @(posedge fast_clk) begin
    if (rst) begin
      hist = {};
      for (int i = 0; i < N + 2; i++) hist.push_back(1'b0);
      exp_q.push_back(1'b0);
    end else begin
      hist.push_front(flag);
      void'(hist.pop_back());
      exp_q.push_back(ref_out());
    end
  end

  always @(negedge fast_clk) begin
    logic e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rst) e = 1'b0;
      check("flag_out", flag_out, e);
    end
  end

  task automatic cyc(input logic f, input int n);
    repeat (n) begin
      @(posedge fast_clk);
      #2 flag = f;
    end
  endtask

  initial begin
    bit seen;
    rst  = 1'b0;
    flag = 1'b0;
    #1 rst = 1'b1;

    // reset held with flag low, then high
    cyc(1'b0, 4);
    cyc(1'b1, 4);
    // release with flag already high, then long high and fall
    @(posedge fast_clk);
    #2 rst = 1'b0;
    cyc(1'b1, 50);
    cyc(1'b0, 10);

    // back-to-back flags
    cyc(1'b1, 3);
    cyc(1'b0, 3);
    cyc(1'b1, 3);
    cyc(1'b0, 10);

    // glitch that no edge ever samples
    @(posedge fast_clk);
    #2 flag = 1'b1;
    #2 flag = 1'b0;
    cyc(1'b0, 8);

    // reset asserted while output is high must drop it without a clock edge
    cyc(1'b1, 1);
    seen = 1'b0;
    for (int i = 0; i < N + 4 && !seen; i++) begin
      @(posedge fast_clk);
      #1 seen = flag_out;
    end
    check("output_rise_seen", seen, 1'b1);
    #1 rst = 1'b1;
    #1 check("async_reset_drop", flag_out, 1'b0);
    flag = 1'b0;
    cyc(1'b0, 3);
    @(posedge fast_clk);
    #2 rst = 1'b0;
    cyc(1'b0, 8);

    // randomized runs, glitches and resets
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        @(posedge fast_clk);
        #3 rst = 1'b1;
        @(posedge fast_clk);
        #3 rst = 1'b0;
      end else if (r == 1) begin
        @(posedge fast_clk);
        #3 flag = ~flag;
        #2 flag = ~flag;
      end else begin
        cyc(1'($urandom_range(0, 1)), $urandom_range(1, 5));
      end
    end

    cyc(1'b0, N + 4);
    @(negedge fast_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flag_synchronizer.md
# flag_synchronizer

Brings a single asynchronous status flag (e.g. a transfer-done flag from the slow SPI/LCD clock domain) into the `fast_clk` domain. A multi-stage flip-flop chain resolves metastability. An optional edge detector turns each rising edge of the flag into exactly one `fast_clk`-wide pulse on `flag_out`. The block sits at the boundary between the SPI master's slow logic and the fast controller logic.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flip-flops; legal range 2..8 (values <2 are a elaboration error).
- `fast_clk`  input  1  destination-domain clock; all state updates on rising edge.
- `rst`  input  1  one clock; reset is asynchronous and active-high; clears all state immediately.
- `flag`  input  1  asynchronous source flag; no timing relation to `fast_clk`.
- `flag_out`  output  1  synchronized flag (pulse or level, see Configuration); registered output.

## Operation
- Registers: sync chain `s[0..SYNC_STAGES-1]`, history bit `d`, output register `flag_out`.
- Each `fast_clk` rising edge: `s[0] <= flag`; `s[i] <= s[i-1]`; `d <= s[SYNC_STAGES-1]`.
- Pulse mode: `flag_out <= s[last] & ~d` — high for exactly one cycle per 0→1 transition of the synchronized flag.
- Level mode: `flag_out <= s[last]`; `d` unused.
- Falling edges of `flag` never produce a pulse.
- `flag` held high indefinitely → exactly one pulse; `flag_out` then stays 0 until `flag` has been low and rises again.
- Reset: `s`, `d`, `flag_out` all 0 asynchronously while `rst`=1; `flag_out`=0 throughout reset.
- Reset release with `flag` already high: chain fills from 0, so one pulse is generated (treated as a rising edge).
- Reset asserted mid-pulse: pulse truncated immediately, no pulse re-issued for that edge unless `flag` still high after release (then rule above applies).
- No combinational path from `flag` to `flag_out`; `flag` feeds only `s[0]`.

## Timing
- Latency: `flag` rising and meeting setup before edge k → `flag_out` high after edge k+SYNC_STAGES (edge k+2 for default), low again after edge k+SYNC_STAGES+1 in pulse mode.
- Metastable capture at edge k may add one cycle of latency (k+SYNC_STAGES+1); never loses an edge that is held long enough.
- Guaranteed capture: `flag` high for ≥2 full `fast_clk` periods; shorter highs may be missed (no pulse) but never produce more than one pulse.
- Re-arm: `flag` must be low for ≥2 `fast_clk` periods between highs for the second rise to yield a second pulse.
- Level mode: `flag_out` follows `flag` (both edges) with the same SYNC_STAGES-edge latency.

## Configuration
- Macro `SYNC_PULSE_EN`.
- Defined: pulse mode (single-cycle pulse per rising edge), `d` register present.
- Not defined: level mode, `flag_out` is the delayed synchronized level; `d` and edge logic omitted.
- Latency to the first high cycle identical in both modes.

## Test plan
- Reset: `rst`=1 with `flag`=0 and `flag`=1, clock running → `flag_out`=0 every cycle; asserting `rst` mid-pulse drops `flag_out` to 0 without waiting for a clock edge.
- Long flag, pulse mode, SYNC_STAGES=2: `flag` 0→1 between edges, held 50 cycles, then 0 → exactly one `flag_out` high cycle, 2–3 edges after the rise; no activity on the fall.
- Back-to-back flags: `flag` high 3 cycles, low 3 cycles, high 3 cycles → exactly two single-cycle pulses, spaced 6 cycles apart.
- Short glitch: `flag` high for less than half a `fast_clk` period, placed away from the clock edges so it is never sampled → no pulse, `flag_out` stays 0.
- Reset release with `flag`=1: deassert `rst` → one pulse SYNC_STAGES edges later, then 0 while `flag` stays high.
- Level mode (macro undefined), SYNC_STAGES=3: `flag` high 10 cycles → `flag_out` high for 10 cycles, delayed by 3–4 edges on both the rise and the fall.
